// File: rtl/mplier_pkg.sv
// Shared constants, Booth digit encoding and the 3:2 compressor for mplier_16x16.
// Build option: MPLIER_16X16_PIPE_EN adds a register between the CSA tree and the final adder.
package mplier_pkg;

   localparam int OP_W   = 16;
   localparam int PROD_W = 32;
   localparam int NUM_PP = 8;

`ifdef MPLIER_16X16_PIPE_EN
   localparam int LATENCY = 3;
`else
   localparam int LATENCY = 2;
`endif

   // One radix-4 Booth digit: magnitude select (x1 or x2) and sign.
   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_digit_t;

   typedef struct packed {
      logic [PROD_W-1:0] sum;
      logic [PROD_W-1:0] carry;
   } csa_t;

   // Carry is pre-shifted to its own weight; the bit shifted out of bit 31 is
   // intentionally lost because the product is taken modulo 2^32.
   function automatic csa_t csa3(input logic [PROD_W-1:0] x,
                                 input logic [PROD_W-1:0] y,
                                 input logic [PROD_W-1:0] z);
      csa_t r;
      r.sum   = x ^ y ^ z;
      r.carry = ((x & y) | (x & z) | (y & z)) << 1;
      return r;
   endfunction

endpackage

// File: rtl/mplier_16x16_booth_enc.sv
// Radix-4 Booth encoder: one overlapping triplet of the multiplier to a digit in {-2,-1,0,+1,+2}.
// Build option: none (MPLIER_16X16_PIPE_EN only affects the top).
module booth_enc
   import mplier_pkg::*;
(
   input  logic [2:0]   bits,
   output booth_digit_t digit
);

   // NOTE: every output is assigned unconditionally, so no latch can be inferred.
   always_comb begin
      digit.one = bits[1] ^ bits[0];
      digit.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
      // 3'b111 is digit zero; keeping neg low there avoids a spurious +1 injection.
      digit.neg = bits[2] & ~(bits[1] & bits[0]);
   end

endmodule

// File: rtl/mplier_16x16.sv
// Signed 16x16->32 multiplier: Booth radix-4 partial products, CSA tree, final adder.
// Build option: MPLIER_16X16_PIPE_EN registers the CSA sum/carry rows (latency 3 instead of 2).
module mplier_16x16
   import mplier_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   output logic [PROD_W-1:0] product
);

   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic              in_valid_q, in_valid_d;
   logic [PROD_W-1:0] product_q, product_d;
   logic              out_valid_q, out_valid_d;

   always_comb begin
      a_d        = a;
      b_d        = b;
      in_valid_d = in_valid;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         in_valid_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         in_valid_q <= in_valid_d;
      end
   end

   // Multiplier sign-extended to 17 bits with the implicit b[-1] = 0 below the LSB.
   logic [OP_W+1:0]   b_ext;
   booth_digit_t      digit  [NUM_PP];
   logic [PROD_W-1:0] pp_row [NUM_PP+1];
   logic [PROD_W-1:0] neg_row;

   assign b_ext = {b_q[OP_W-1], b_q, 1'b0};

   for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
      logic [OP_W:0] mag;
      logic [OP_W:0] sel;

      booth_enc u_enc (
         .bits  (b_ext[2*i+2 : 2*i]),
         .digit (digit[i])
      );

      always_comb begin
         mag = '0;
         if (digit[i].one)
            mag = {a_q[OP_W-1], a_q};
         else if (digit[i].two)
            mag = {a_q, 1'b0};
         sel = mag ^ {(OP_W+1){digit[i].neg}};
      end

      assign pp_row[i] = {{(PROD_W-OP_W-1){sel[OP_W]}}, sel} << (2*i);
   end

   // The +1 completing each one's-complement negation, at the LSB weight of its row.
   always_comb begin
      neg_row = '0;
      for (int i = 0; i < NUM_PP; i++)
         neg_row[2*i] = digit[i].neg;
   end

   assign pp_row[NUM_PP] = neg_row;

   // 9 rows -> 6 -> 4 -> 3 -> 2.
   csa_t l1 [3];
   csa_t l2 [2];
   csa_t l3, l4;

   for (genvar i = 0; i < 3; i++) begin : g_l1
      assign l1[i] = csa3(pp_row[3*i], pp_row[3*i+1], pp_row[3*i+2]);
   end

   assign l2[0] = csa3(l1[0].sum,   l1[0].carry, l1[1].sum);
   assign l2[1] = csa3(l1[1].carry, l1[2].sum,   l1[2].carry);
   assign l3    = csa3(l2[0].sum,   l2[0].carry, l2[1].sum);
   assign l4    = csa3(l3.sum,      l3.carry,    l2[1].carry);

   logic [PROD_W-1:0] add_sum, add_carry;
   logic              add_valid;

`ifdef MPLIER_16X16_PIPE_EN
   logic [PROD_W-1:0] sum_q, sum_d, carry_q, carry_d;
   logic              mid_valid_q, mid_valid_d;

   always_comb begin
      sum_d       = l4.sum;
      carry_d     = l4.carry;
      mid_valid_d = in_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         carry_q     <= '0;
         mid_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         mid_valid_q <= mid_valid_d;
      end
   end

   assign add_sum   = sum_q;
   assign add_carry = carry_q;
   assign add_valid = mid_valid_q;
`else
   assign add_sum   = l4.sum;
   assign add_carry = l4.carry;
   assign add_valid = in_valid_q;
`endif

   // Bubbles leave the last product on the output rather than clearing it.
   always_comb begin
      out_valid_d = add_valid;
      product_d   = product_q;
      if (add_valid)
         product_d = add_sum + add_carry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign product   = product_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mplier_16x16.sv
// Self-checking bench for mplier_16x16: spec vector table, sweep, bubbles, resets, random stream.
// Build option: MPLIER_16X16_PIPE_EN selects the 3-cycle latency expectation.
module tb_mplier_16x16;

`ifdef MPLIER_16X16_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam int MAXC = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic [31:0] product;

   mplier_16x16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .product   (product)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   bit          hist_rst [MAXC];
   bit          hist_v   [MAXC];
   logic [15:0] hist_a   [MAXC];
   logic [15:0] hist_b   [MAXC];
   logic [31:0] model_prod = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // Inputs are captured at this step's edge; the product is visible LAT-1 edges later.
   task automatic step(input bit r, input bit v, input logic [15:0] ia, input logic [15:0] ib);
      int  s;
      bit  ev;
      int  sa, sb;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      rst = r; in_valid = v; a = ia; b = ib;
      hist_rst[cyc] = r; hist_v[cyc] = v; hist_a[cyc] = ia; hist_b[cyc] = ib;
      @(posedge clk);
      #1;
      if (r) begin
         ev         = 1'b0;
         model_prod = '0;
      end else begin
         s  = cyc - (LAT - 1);
         ev = (s >= 0) && hist_v[s];
         if (s >= 0)
            for (int j = s; j < cyc; j++)
               if (hist_rst[j]) ev = 1'b0;
         if (ev) begin
            sa = int'($signed(hist_a[s]));
            sb = int'($signed(hist_b[s]));
            model_prod = 32'(sa * sb);
         end
      end
      check("out_valid", {31'b0, out_valid}, {31'b0, ev});
      check("product", product, model_prod);
      cyc++;
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{16'd1000, 16'd1000, 32'd1000000};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'd1};
      vecs[2] = '{16'h8000, 16'h8000, 32'h4000_0000};
      vecs[3] = '{16'h8000, 16'h7FFF, 32'hC000_8000};
      vecs[4] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
      vecs[5] = '{16'd1234, 16'd0,    32'd0};
      vecs[6] = '{16'hFFF9, 16'd3,    32'hFFFF_FFEB};

      // Reset held two cycles with in_valid high.
      step(1'b1, 1'b1, 16'd5, 16'd6);
      step(1'b1, 1'b1, 16'd7, 16'd8);
      check("reset_valid", {31'b0, out_valid}, 32'd0);
      check("reset_product", product, 32'd0);

      // First result after reset appears at the fixed latency.
      step(1'b0, 1'b1, 16'd3, 16'd4);
      repeat (LAT - 1) step(1'b0, 1'b0, '0, '0);
      check("first_after_reset", product, 32'd12);

      foreach (vecs[i]) begin
         step(1'b0, 1'b1, vecs[i].a, vecs[i].b);
         repeat (LAT - 1) step(1'b0, 1'b0, '0, '0);
         check("vec_valid", {31'b0, out_valid}, 32'd1);
         check("vec_product", product, vecs[i].exp);
      end

      // Back-to-back sweep over the raw operand range.
      for (int i = 0; i <= 65; i++)
         step(1'b0, 1'b1, 16'(i * 1000), 16'(65000 - i * 1000));
      repeat (LAT) step(1'b0, 1'b0, '0, '0);

      // Bubbles: product must hold through the invalid slots.
      step(1'b0, 1'b1, 16'hFFF9, 16'd3);
      step(1'b0, 1'b0, 16'h1111, 16'h2222);
      step(1'b0, 1'b1, 16'd0, 16'd12345);
      step(1'b0, 1'b0, 16'h3333, 16'h4444);
      repeat (LAT) step(1'b0, 1'b0, '0, '0);
      check("bubble_hold", product, 32'd0);

      // Mid-stream reset with operations in flight.
      step(1'b0, 1'b1, 16'd100, 16'd200);
      step(1'b0, 1'b1, 16'd300, 16'd400);
      step(1'b1, 1'b1, 16'd500, 16'd600);
      repeat (LAT + 1) step(1'b0, 1'b0, '0, '0);
      check("midreset_valid", {31'b0, out_valid}, 32'd0);
      check("midreset_product", product, 32'd0);

      // Random stream with occasional bubbles and resets.
      for (int i = 0; i < 400; i++)
         step(bit'($urandom_range(49) == 0), bit'($urandom_range(3) != 0),
              16'($urandom), 16'($urandom));
      repeat (LAT) step(1'b0, 1'b0, '0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
